gpio_io_bridge: RTL and testbench
=================================

Name: gpio_io_bridge

Overview:
- Board-side peripheral for the CPU's GPIO pair: sits between the board and the core.
- Input path: synchronises and debounces slide switches, then drives the CPU's 32-bit input word.
- Output path: watches the CPU's 32-bit output word. On each change it runs a multi-cycle binary-to-BCD conversion (double-dabble) and drives eight active-low 7-segment digits.

Parameters:
- SW_WIDTH, 18: number of switch inputs, 1..32.
- DEBOUNCE_CYCLES, 250000: required stable cycles before a switch change is committed (5 ms at 50 MHz), >=1.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  SW_WIDTH  raw, asynchronous switch pins.
- cpu_in  output  32  debounced switches zero-extended; connects to CPU io0_in.
- cpu_out  input  32  CPU io2_out value.
- hex0..hex7  output  7 each  segments {g,f,e,d,c,b,a}, active-low; hex0 is the least-significant digit.
- busy  output  1  conversion in progress.
- overflow  output  1  last converted value >= 100000000.

Behaviour:
- Reset (async, rst=1):
  - cpu_in=0, busy=0, overflow=0.
  - Synchroniser flops, candidate and debounce counter cleared; shadow=0.
  - hex0..hex7=7'h40 ("0").
  - FSM forced to IDLE; any in-flight conversion is discarded.
- Switch path:
  - 2-flop synchroniser per bit produces sync.
  - Each cycle, evaluated in priority order:
    - if sync != cand: cand<=sync, cnt<=0;
    - else if cnt==DEBOUNCE_CYCLES-1: cpu_in<={0,cand}, cnt holds;
    - else cnt<=cnt+1.
  - A clean pin change reaches cpu_in exactly DEBOUNCE_CYCLES+3 edges later.
  - Any glitch restarts the count.
- Display FSM states: IDLE, SHIFT, LATCH.
  - IDLE: if cpu_out != shadow, then:
    - shadow<=cpu_out, bin<=cpu_out, bcd(40-bit)<=0, iter<=0;
    - busy<=1; go SHIFT.
  - SHIFT, one iteration per cycle:
    - for each of the 10 BCD nibbles, add 3 if >=5;
    - then shift {bcd,bin} left 1;
    - iter++; after the 32nd iteration go LATCH.
  - LATCH:
    - hexN<=seg(bcd nibble N) for N=0..7;
    - overflow<=(nibble8|nibble9)!=0;
    - busy<=0; go IDLE.
- Latency: capture edge E0, shifts E1..E32, display and busy=0 at E33. busy is high 33 cycles.
- cpu_out changes during SHIFT/LATCH are not sampled; the conversion completes with the old value. IDLE then sees the mismatch against shadow and restarts on the next edge. Intermediate values may be skipped; the final display always matches the last stable cpu_out.
- Segment codes, digits 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). Blank is 7F.
- Nibbles >9 cannot occur; no default case is required beyond blank.

Optional Feature:
- Macro: GPIO_IO_BRIDGE_BLANK_EN.
- When defined: leading-zero blanking in LATCH. Any digit N>=1 whose nibble and all higher displayed nibbles (N..7) are zero shows 7F. hex0 always shows its digit. Reset state is hex0=40, hex1..hex7=7F.
- When undefined: all eight digits always show their value, including leading zeros.

Test Plan:
- Reset with rst pulsed mid-cycle (async) -> cpu_in=0, busy=0, overflow=0, all hexN=40 (feature off), with no clock edge needed.
- DEBOUNCE_CYCLES=4, sw=18'h2A5A5 held -> cpu_in=32'h0002A5A5 at exactly edge 7 after the change. A 3-cycle toggle pulse on sw[0] -> cpu_in unchanged.
- cpu_out=32'd12345678 -> busy high 33 cycles; hex7..hex0 = 79,24,30,19,12,02,78,00; overflow=0.
- cpu_out=32'hFFFFFFFF -> hex7..hex0 show 94967295 (10,19,10,02,78,24,10,12); overflow=1.
- cpu_out 32'd5 then 32'd42 at E10 of the conversion -> "5" latched at E33, a new conversion starts at E34, "42" displayed at E67. With BLANK_EN: hex1=19, hex0=24, hex2..7=7F.
- rst asserted at E15 of a conversion -> busy=0 immediately, display returns to 40s, shadow=0. After release, a nonzero cpu_out triggers a fresh conversion.

Source files
------------

// File: rtl/gpio_io_bridge.sv
// Board-side GPIO bridge: debounced switches into the CPU, CPU output word to eight 7-segment digits.
// Define GPIO_IO_BRIDGE_BLANK_EN to blank leading zeros on hex1..hex7.
module gpio_io_bridge #(
   parameter int SW_WIDTH        = 18,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SW_WIDTH-1:0] sw,
   output logic [31:0]         cpu_in,
   input  logic [31:0]         cpu_out,
   output logic [6:0]          hex0,
   output logic [6:0]          hex1,
   output logic [6:0]          hex2,
   output logic [6:0]          hex3,
   output logic [6:0]          hex4,
   output logic [6:0]          hex5,
   output logic [6:0]          hex6,
   output logic [6:0]          hex7,
   output logic                busy,
   output logic                overflow
);
   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [6:0]      SEG_BLANK = 7'h7F;
`ifdef GPIO_IO_BRIDGE_BLANK_EN
   localparam logic [6:0]      SEG_RST_HI = SEG_BLANK;
`else
   localparam logic [6:0]      SEG_RST_HI = 7'h40;
`endif

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

   logic [SW_WIDTH-1:0] r_sync1, r_sync2, r_cand;
   logic [CNT_W-1:0]    r_cnt;
   logic [31:0]         r_cpu_in;
   state_t              r_state, w_state_next;
   logic [31:0]         r_shadow, r_bin;
   logic [39:0]         r_bcd;
   logic [39:0]         w_bcd_adj;
   logic [4:0]          r_iter;
   logic [6:0]          r_hex [0:7];
   logic [6:0]          w_seg [0:7];
   logic                r_overflow;

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'h40;
         4'd1:    f_seg = 7'h79;
         4'd2:    f_seg = 7'h24;
         4'd3:    f_seg = 7'h30;
         4'd4:    f_seg = 7'h19;
         4'd5:    f_seg = 7'h12;
         4'd6:    f_seg = 7'h02;
         4'd7:    f_seg = 7'h78;
         4'd8:    f_seg = 7'h00;
         4'd9:    f_seg = 7'h10;
         default: f_seg = SEG_BLANK;
      endcase
   endfunction

   // Count restarts whenever the synchronised value disagrees with the candidate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_cand   <= '0;
         r_cnt    <= '0;
         r_cpu_in <= '0;
      end else begin
         r_sync1 <= sw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_cpu_in <= 32'(r_cand);
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_adj
         assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                       r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_seg
`ifdef GPIO_IO_BRIDGE_BLANK_EN
         if (gi > 0) begin : g_blank
            assign w_seg[gi] = (r_bcd[31:gi*4] == '0) ? SEG_BLANK : f_seg(r_bcd[gi*4 +: 4]);
         end else begin : g_digit
            assign w_seg[gi] = f_seg(r_bcd[gi*4 +: 4]);
         end
`else
         assign w_seg[gi] = f_seg(r_bcd[gi*4 +: 4]);
`endif
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (cpu_out != r_shadow) w_state_next = S_SHIFT;
         S_SHIFT: if (r_iter == 5'd31) w_state_next = S_LATCH;
         S_LATCH: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != S_IDLE);
      overflow = r_overflow;
   end

   // Double-dabble datapath; cpu_out is only sampled while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow   <= '0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_iter     <= '0;
         r_overflow <= 1'b0;
         r_hex[0]   <= 7'h40;
         for (int n = 1; n < 8; n++) r_hex[n] <= SEG_RST_HI;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_out != r_shadow) begin
                  r_shadow <= cpu_out;
                  r_bin    <= cpu_out;
                  r_bcd    <= '0;
                  r_iter   <= '0;
               end
            end
            S_SHIFT: begin
               {r_bcd, r_bin} <= {w_bcd_adj[38:0], r_bin, 1'b0};
               r_iter         <= r_iter + 5'd1;
            end
            S_LATCH: begin
               for (int n = 0; n < 8; n++) r_hex[n] <= w_seg[n];
               r_overflow <= (r_bcd[39:32] != 8'd0);
            end
            default: ;
         endcase
      end
   end

   assign cpu_in = r_cpu_in;
   assign hex0   = r_hex[0];
   assign hex1   = r_hex[1];
   assign hex2   = r_hex[2];
   assign hex3   = r_hex[3];
   assign hex4   = r_hex[4];
   assign hex5   = r_hex[5];
   assign hex6   = r_hex[6];
   assign hex7   = r_hex[7];
endmodule

// File: tb/tb_gpio_io_bridge.sv
// Scoreboard bench for gpio_io_bridge: directed switch and display vectors, monitors compare queued expectations.
module tb_gpio_io_bridge;
   localparam int SW_W = 18;

`ifdef GPIO_IO_BRIDGE_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif
   localparam logic [55:0] E_RST  = {{7{LZ}}, 7'h40};
   localparam logic [55:0] E_1234 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
   localparam logic [55:0] E_FFFF = {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12};
   localparam logic [55:0] E_5    = {{7{LZ}}, 7'h12};
   localparam logic [55:0] E_42   = {{6{LZ}}, 7'h19, 7'h24};

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [SW_W-1:0] sw = '0;
   logic [31:0]     cpu_in;
   logic [31:0]     cpu_out = '0;
   logic [6:0]      hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic            busy, overflow;

   int n_checks = 0;
   int n_errors = 0;
   logic [56:0] q_disp[$];
   logic [31:0] q_cpu[$];

   gpio_io_bridge #(.SW_WIDTH(SW_W), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .sw(sw), .cpu_in(cpu_in), .cpu_out(cpu_out),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
      .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
      .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [55:0] hexv();
      return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Display monitor: each completed conversion (busy falling) pops one expectation.
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_busy <= 1'b0;
      end else begin
         if (prev_busy && !busy) begin
            if (q_disp.size() == 0) begin
               check("disp_unexpected", 64'({hexv(), overflow}), 64'h0);
               if (hexv() == 56'h0 && overflow == 1'b0) begin
                  n_errors++;
                  $display("FAIL disp_unexpected: got conversion with empty queue required none");
               end
            end else begin
               check("disp", 64'({hexv(), overflow}), 64'(q_disp.pop_front()));
            end
         end
         prev_busy <= busy;
      end
   end

   // Switch monitor: every committed change of cpu_in pops one expectation.
   logic [31:0] prev_cpu_in = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_cpu_in <= cpu_in;
      end else begin
         if (cpu_in !== prev_cpu_in) begin
            if (q_cpu.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL cpu_in_unexpected: got %h required %h", cpu_in, prev_cpu_in);
            end else begin
               check("cpu_in", 64'(cpu_in), 64'(q_cpu.pop_front()));
            end
         end
         prev_cpu_in <= cpu_in;
      end
   end

   task automatic run_conv(input logic [31:0] v, input logic [56:0] exp, input string name);
      int cnt;
      @(negedge clk);
      cpu_out = v;
      q_disp.push_back(exp);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (busy) cnt++;
         else if (cnt > 0) break;
      end
      check(name, 64'(cnt), 64'd33);
   endtask

   initial begin
      #3 rst = 1'b1;
      #1;
      check("rst_cpu_in", 64'(cpu_in), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_ovf", 64'(overflow), 64'h0);
      check("rst_hex", 64'(hexv()), 64'(E_RST));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Clean switch change lands on edge 7.
      sw = 18'h2A5A5;
      q_cpu.push_back(32'h0002A5A5);
      repeat (6) @(posedge clk);
      #1 check("deb_edge6", 64'(cpu_in), 64'h0);
      @(posedge clk);
      #1 check("deb_edge7", 64'(cpu_in), 64'h0002A5A5);

      // Three-cycle glitch must not commit.
      @(negedge clk);
      sw = sw ^ 18'h1;
      repeat (3) @(negedge clk);
      sw = 18'h2A5A5;
      repeat (20) @(negedge clk);
      check("deb_glitch", 64'(cpu_in), 64'h0002A5A5);

      run_conv(32'd12345678, {E_1234, 1'b0}, "busy_len_1234");
      check("hex_1234", 64'(hexv()), 64'(E_1234));
      run_conv(32'd5, {E_5, 1'b0}, "busy_len_5");
      run_conv(32'hFFFFFFFF, {E_FFFF, 1'b1}, "busy_len_ffff");
      check("ovf_ffff", 64'(overflow), 64'h1);

      // 5 then 42 mid-conversion: 42 is picked up only after the first result.
      @(negedge clk);
      cpu_out = 32'd5;
      q_disp.push_back({E_5, 1'b0});
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      cpu_out = 32'd42;
      q_disp.push_back({E_42, 1'b0});
      repeat (24) @(posedge clk);
      #1;
      check("e33_busy", 64'(busy), 64'h0);
      check("e33_hex", 64'(hexv()), 64'(E_5));
      @(posedge clk);
      #1 check("e34_busy", 64'(busy), 64'h1);
      repeat (32) @(posedge clk);
      #1 check("e66_busy", 64'(busy), 64'h1);
      @(posedge clk);
      #1;
      check("e67_busy", 64'(busy), 64'h0);
      check("e67_hex", 64'(hexv()), 64'(E_42));

      run_conv(32'hFFFFFFFF, {E_FFFF, 1'b1}, "busy_len_ffff2");

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk);
      cpu_out = 32'd12345678;
      @(posedge clk);
      repeat (15) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_hex", 64'(hexv()), 64'(E_RST));
      check("abort_ovf", 64'(overflow), 64'h0);
      check("abort_cpu_in", 64'(cpu_in), 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      q_disp.push_back({E_1234, 1'b0});
      q_cpu.push_back(32'h0002A5A5);
      @(posedge clk);
      #1 check("restart_busy", 64'(busy), 64'h1);

      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q_disp.size() == 0 && q_cpu.size() == 0) break;
      end
      repeat (2) @(negedge clk);
      check("q_disp_empty", 64'(q_disp.size()), 64'h0);
      check("q_cpu_empty", 64'(q_cpu.size()), 64'h0);
      check("final_hex", 64'(hexv()), 64'(E_1234));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: got timeout required completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   end
endmodule
